// File: rtl/matrix_c_drain.sv
// Captures an N x N multiplier result on a rising edge of mm_done and streams it out row-major
// over a valid/ready port. Optional build macro MATRIX_C_DRAIN_RELU_EN zeroes negative elements.
module matrix_c_drain #(
  parameter int unsigned ARRAY_SIZE = 16,
  parameter int unsigned DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mm_done,
  input  logic [DATA_W-1:0] mm_c [ARRAY_SIZE*ARRAY_SIZE],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_row_last,
  output logic              out_last,
  output logic              busy,
  output logic              drain_done,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int unsigned Depth = ARRAY_SIZE * ARRAY_SIZE;
  localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned ColW  = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(ARRAY_SIZE - 1);

  typedef enum logic {StIdle, StStream} state_e;

  state_e            state_q, state_d;
  logic              mm_done_q;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [ColW-1:0]   col_q, col_d;
  logic              drain_done_q, drain_done_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] buf_q [Depth];
  logic [DATA_W-1:0] elem;

  logic capture, xfer, final_xfer, load, drop;

  assign capture    = mm_done & ~mm_done_q;
  assign xfer       = (state_q == StStream) & out_ready;
  assign final_xfer = xfer & (idx_q == LastIdx);
  // A new result is only accepted when nothing is pending after this cycle.
  assign load       = capture & ((state_q == StIdle) | final_xfer);
  assign drop       = capture & (state_q == StStream) & ~final_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mm_done_q    <= 1'b0;
      idx_q        <= '0;
      col_q        <= '0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mm_done_q    <= mm_done;
      idx_q        <= idx_d;
      col_q        <= col_d;
      drain_done_q <= drain_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (load) begin
      buf_q <= mm_c;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    col_d        = col_q;
    drain_done_d = final_xfer;
    overrun_d    = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (capture) state_d = StStream;
      end
      StStream: begin
        if (final_xfer && !capture) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      idx_d = '0;
      col_d = '0;
    end else if (xfer) begin
      idx_d = idx_q + 1'b1;
      col_d = (col_q == LastCol) ? '0 : col_q + 1'b1;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    out_valid    = (state_q == StStream);
    busy         = (state_q == StStream);
    elem         = buf_q[idx_q];
    out_data     = '0;
    if (out_valid) begin
`ifdef MATRIX_C_DRAIN_RELU_EN
      out_data = elem[DATA_W-1] ? '0 : elem;
`else
      out_data = elem;
`endif
    end
    out_row_last = out_valid & (col_q == LastCol);
    out_last     = out_valid & (idx_q == LastIdx);
    drain_done   = drain_done_q;
    overrun      = overrun_q;
  end

endmodule

// File: tb/tb_matrix_c_drain.sv
// Self-checking bench for matrix_c_drain: a cycle model with an expected-element queue checks
// every output each cycle, driven by a reset/capture table and hand-written corner sequences.
module tb_matrix_c_drain;

  localparam int unsigned N     = 16;
  localparam int unsigned Depth = N * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mm_done = 1'b0;
  logic [15:0] mm_c [Depth];
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_row_last, out_last, busy, drain_done, overrun;
  logic        clr_overrun = 1'b0;

  matrix_c_drain #(.ARRAY_SIZE(N), .DATA_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .mm_done      (mm_done),
    .mm_c         (mm_c),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row_last (out_row_last),
    .out_last     (out_last),
    .busy         (busy),
    .drain_done   (drain_done),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        row_last;
    logic        last;
  } elem_t;

  typedef struct {
    logic        rst;
    logic        done;
    logic        rdy;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  elem_t q[$];
  int    vectors = 0;
  int    errors  = 0;
  int    xfers   = 0;
  int    drains  = 0;
  logic  prev_done = 1'b0;
  logic  exp_drain = 1'b0;
  logic  exp_ovr   = 1'b0;
  logic  armed     = 1'b0;

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_out(input logic [15:0] v);
`ifdef MATRIX_C_DRAIN_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic fill(input int base);
    for (int k = 0; k < Depth; k++) mm_c[k] = 16'(base + k);
  endtask

  task automatic load_expected();
    elem_t e;
    for (int k = 0; k < Depth; k++) begin
      e.data     = model_out(mm_c[k]);
      e.row_last = ((k % N) == N - 1);
      e.last     = (k == Depth - 1);
      q.push_back(e);
    end
    xfers = 0;
  endtask

  // One clock: check current outputs against the model, advance the model, then check the
  // registered pulse/flag outputs after the edge.
  task automatic tick();
    logic model_busy, x, fin, cap, drop;
    #1;
    model_busy = (q.size() != 0);
    if (armed) begin
      check1("out_valid", out_valid, model_busy);
      check1("busy", busy, model_busy);
      if (model_busy) begin
        check16("out_data", out_data, q[0].data);
        check1("out_row_last", out_row_last, q[0].row_last);
        check1("out_last", out_last, q[0].last);
      end else begin
        check1("idle_row_last", out_row_last, 1'b0);
        check1("idle_last", out_last, 1'b0);
      end
    end
    x    = model_busy && out_ready;
    fin  = x && (q.size() == 1);
    cap  = mm_done && !prev_done;
    drop = cap && model_busy && !fin;
    if (rst) begin
      q.delete();
      exp_drain = 1'b0;
      exp_ovr   = 1'b0;
      prev_done = 1'b0;
      armed     = 1'b1;
    end else begin
      if (x) begin
        void'(q.pop_front());
        xfers++;
      end
      exp_drain = fin;
      if (fin) drains++;
      if (cap && !drop) load_expected();
      if (drop) exp_ovr = 1'b1;
      else if (clr_overrun) exp_ovr = 1'b0;
      prev_done = mm_done;
    end
    @(posedge clk);
    #1;
    if (armed) begin
      check1("drain_done", drain_done, exp_drain);
      check1("overrun", overrun, exp_ovr);
    end
  endtask

  task automatic pulse_done();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
  endtask

  task automatic wait_xfers(input int n);
    out_ready = 1'b1;
    for (int c = 0; c < 1000 && xfers < n && q.size() != 0; c++) tick();
    check_int("reach_xfer", xfers, n);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1
  task automatic drain(input int mode);
    for (int c = 0; c < 3000 && q.size() != 0; c++) begin
      out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      tick();
    end
    check_int("drain_budget", q.size(), 0);
    out_ready = 1'b0;
    tick();
  endtask

  vec_t tbl[8];

  initial begin
    fill(0);
    //            rst   done  rdy   valid  data
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd0};  // done already high out of reset
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd2};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

    for (int i = 0; i < 8; i++) begin
      rst       = tbl[i].rst;
      mm_done   = tbl[i].done;
      out_ready = tbl[i].rdy;
      tick();
      check1("tbl_valid", out_valid, tbl[i].exp_valid);
      check16("tbl_data", out_data, tbl[i].exp_data);
      if (tbl[i].rst) check1("tbl_rst_ovr", overrun, 1'b0);
    end
    rst = 1'b0;

    // Full stream at full rate; mm_done held high several cycles captures only once.
    drains = 0;
    fill(0);
    mm_done = 1'b1;
    repeat (3) tick();
    mm_done = 1'b0;
    drain(0);
    check_int("drains_full", drains, 1);

    // Stalled stream with ready 1,0,0,1.
    drains = 0;
    pulse_done();
    drain(1);
    check_int("drains_stall", drains, 1);

    // Dropped capture mid-stream; the new mm_c must not reach the buffer.
    fill(0);
    pulse_done();
    wait_xfers(100);
    fill(5000);
    pulse_done();
    tick();
    check1("ovr_set", overrun, 1'b1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check1("ovr_clr", overrun, 1'b0);
    wait_xfers(150);
    clr_overrun = 1'b1;
    pulse_done();  // drop coincides with clear: set wins
    clr_overrun = 1'b0;
    check1("ovr_set_wins", overrun, 1'b1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    drain(0);

    // Capture on the cycle of the final transfer reloads without leaving STREAM.
    drains = 0;
    fill(0);
    pulse_done();
    out_ready = 1'b1;
    for (int c = 0; c < 1000 && q.size() > 1; c++) tick();
    fill(1000);
    pulse_done();
    check1("reload_busy", busy, 1'b1);
    check16("reload_first", out_data, 16'd1000);
    drain(0);
    check_int("drains_reload", drains, 2);

    // Reset mid-stream aborts without a drain_done pulse, then a new capture restarts.
    drains = 0;
    fill(0);
    pulse_done();
    wait_xfers(50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("abort_valid", out_valid, 1'b0);
    check1("abort_busy", busy, 1'b0);
    tick();
    check_int("drains_abort", drains, 0);
    pulse_done();
    check16("restart_first", out_data, 16'd0);
    drain(0);
    check_int("drains_restart", drains, 1);

`ifdef MATRIX_C_DRAIN_RELU_EN
    fill(0);
    mm_c[0] = 16'hFFFF;
    mm_c[1] = 16'h0005;
    pulse_done();
    check16("relu_neg", out_data, 16'd0);
    out_ready = 1'b1;
    tick();
    check16("relu_pos", out_data, 16'd5);
    drain(0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
